// File: rtl/sdram_line_frontend.sv
// One-line byte store between the 8-bit system bus and the SDRAM line-transfer port.
// Defining SDRAM_FE_FLUSH_EN adds flush/flush_done and the FLUSH_WB writeback state.
module sdram_line_frontend #(
    parameter int ADDR_WIDTH = 23,
    parameter int LINE_BYTES = 32
) (
    input  logic                                     sys_clk,
    input  logic                                     rst,
    input  logic                                     bus_sel,
    input  logic                                     bus_write,
    input  logic [ADDR_WIDTH-1:0]                    bus_addr,
    input  logic [7:0]                               bus_wdata,
    output logic [7:0]                               bus_rdata,
    output logic                                     bus_ready,
    output logic                                     line_req,
    output logic                                     line_we,
    output logic [ADDR_WIDTH-$clog2(LINE_BYTES)-1:0] line_addr,
    input  logic                                     line_ack,
    output logic [7:0]                               wb_data,
    output logic                                     wb_valid,
    input  logic                                     wb_ready,
`ifdef SDRAM_FE_FLUSH_EN
    input  logic                                     flush,
    output logic                                     flush_done,
`endif
    input  logic [7:0]                               fill_data,
    input  logic                                     fill_valid
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int TAG_W = ADDR_WIDTH - OFF_W;
    localparam logic [OFF_W:0] CNT_FULL = (OFF_W + 1)'(LINE_BYTES);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_RESP     = 3'd2;
    localparam logic [2:0] S_WB       = 3'd3;
    localparam logic [2:0] S_FILL     = 3'd4;
`ifdef SDRAM_FE_FLUSH_EN
    localparam logic [2:0] S_FLUSH_WB = 3'd5;
`endif

    logic [2:0]       state_q, state_d;
    logic [OFF_W:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] req_line_q, req_line_d;
    logic             valid_q, valid_d;
    logic             dirty_q, dirty_d;
    logic             ack_q, ack_d;
    logic             gap_q, gap_d;
    logic [7:0]       rdata_q, rdata_d;

    logic [7:0]       store_q [LINE_BYTES];
    logic             store_we;
    logic [OFF_W-1:0] store_waddr;
    logic [7:0]       store_wdata;

    logic [OFF_W-1:0] offset;
    logic [TAG_W-1:0] addr_line;
    logic             hit, wb_active, cnt_full, ack_seen;

    assign offset    = bus_addr[OFF_W-1:0];
    assign addr_line = bus_addr[ADDR_WIDTH-1:OFF_W];
    assign hit       = valid_q && (tag_q == addr_line);
    assign cnt_full  = (cnt_q == CNT_FULL);
`ifdef SDRAM_FE_FLUSH_EN
    assign wb_active = (state_q == S_WB) || (state_q == S_FLUSH_WB);
`else
    assign wb_active = (state_q == S_WB);
`endif

    // gap_q holds line_req low for one cycle between a writeback and its refill.
    assign line_req  = wb_active || ((state_q == S_FILL) && !gap_q);
    assign line_we   = wb_active;
    assign line_addr = wb_active ? tag_q : req_line_q;
    assign ack_seen  = ack_q || (line_req && line_ack);
    assign wb_valid  = wb_active && !cnt_full;
    assign wb_data   = wb_valid ? store_q[cnt_q[OFF_W-1:0]] : 8'h00;
    assign bus_ready = (state_q == S_RESP);
    assign bus_rdata = rdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        req_line_d  = req_line_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        ack_d       = ack_q;
        gap_d       = gap_q;
        rdata_d     = rdata_q;
        store_we    = 1'b0;
        store_waddr = offset;
        store_wdata = bus_wdata;
`ifdef SDRAM_FE_FLUSH_EN
        flush_done  = 1'b0;
`endif
        if (line_req && line_ack) ack_d = 1'b1;
        if (wb_valid && wb_ready) cnt_d = cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus_sel) begin
                    state_d = S_LOOKUP;
                end
`ifdef SDRAM_FE_FLUSH_EN
                else if (flush) begin
                    if (valid_q && dirty_q) state_d = S_FLUSH_WB;
                    else flush_done = 1'b1;
                end
`endif
            end
            S_LOOKUP: begin
                req_line_d = addr_line;
                if (hit) begin
                    if (bus_write) begin
                        store_we = 1'b1;
                        dirty_d  = 1'b1;
                    end else begin
                        rdata_d = store_q[offset];
                    end
                    state_d = S_RESP;
                end else if (valid_q && dirty_q) begin
                    state_d = S_WB;
                end else begin
                    valid_d = 1'b0;
                    state_d = S_FILL;
                end
            end
            S_RESP: state_d = S_IDLE;
            S_WB: begin
                if (cnt_full && ack_seen) begin
                    dirty_d = 1'b0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    ack_d   = 1'b0;
                    gap_d   = 1'b1;
                    state_d = S_FILL;
                end
            end
`ifdef SDRAM_FE_FLUSH_EN
            S_FLUSH_WB: begin
                if (cnt_full && ack_seen) begin
                    dirty_d    = 1'b0;
                    cnt_d      = '0;
                    ack_d      = 1'b0;
                    flush_done = 1'b1;
                    state_d    = S_IDLE;
                end
            end
`endif
            S_FILL: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    if (fill_valid && !cnt_full) begin
                        store_we    = 1'b1;
                        store_waddr = cnt_q[OFF_W-1:0];
                        store_wdata = fill_data;
                        cnt_d       = cnt_q + 1'b1;
                    end
                    // The re-lookup serves the held access, including write-allocate.
                    if (cnt_full && ack_seen) begin
                        tag_d   = req_line_q;
                        valid_d = 1'b1;
                        dirty_d = 1'b0;
                        cnt_d   = '0;
                        ack_d   = 1'b0;
                        state_d = S_LOOKUP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tag_q      <= '0;
            req_line_q <= '0;
            valid_q    <= 1'b0;
            dirty_q    <= 1'b0;
            ack_q      <= 1'b0;
            gap_q      <= 1'b0;
            rdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tag_q      <= tag_d;
            req_line_q <= req_line_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            ack_q      <= ack_d;
            gap_q      <= gap_d;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (store_we) store_q[store_waddr] <= store_wdata;
    end
endmodule

// File: tb/tb_sdram_line_frontend.sv
// Directed bench for sdram_line_frontend: a small SDRAM-controller model answers line
// transfers while each test task checks bus results, stream contents and handshake timing.
module tb_sdram_line_frontend;
    localparam int AW = 23;
    localparam int LB = 32;
    localparam int LW = AW - 5;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic          bus_sel = 1'b0;
    logic          bus_write = 1'b0;
    logic [AW-1:0] bus_addr = '0;
    logic [7:0]    bus_wdata = 8'h00;
    logic [7:0]    bus_rdata;
    logic          bus_ready;
    logic          line_req;
    logic          line_we;
    logic [LW-1:0] line_addr;
    logic          line_ack = 1'b0;
    logic [7:0]    wb_data;
    logic          wb_valid;
    logic          wb_ready = 1'b0;
    logic [7:0]    fill_data = 8'h00;
    logic          fill_valid = 1'b0;
`ifdef SDRAM_FE_FLUSH_EN
    logic          flush = 1'b0;
    logic          flush_done;
`endif

    sdram_line_frontend dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .bus_sel    (bus_sel),
        .bus_write  (bus_write),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ready  (bus_ready),
        .line_req   (line_req),
        .line_we    (line_we),
        .line_addr  (line_addr),
        .line_ack   (line_ack),
        .wb_data    (wb_data),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
`ifdef SDRAM_FE_FLUSH_EN
        .flush      (flush),
        .flush_done (flush_done),
`endif
        .fill_data  (fill_data),
        .fill_valid (fill_valid)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] wb_q[$];
    logic [7:0] exp_q[$];

    logic [7:0]    o_rdata;
    logic [LW-1:0] o_fill_addr, o_wb_addr;
    int o_ready_cyc, o_comp_cyc, o_fall_cyc, o_req_cycles, o_we_cycles;
    int o_fill_first, o_wb_last;
    logic o_ab_req, o_ab_ready;

    // Inputs change 2 time units after the rising edge; outputs are read 1 unit later.
    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    // One bus access with the controller model answering any line transfers.
    // ack_delay: fill ack cycle relative to the last fill byte; abort_at >= 0 pulses rst at that fill count.
    task automatic do_access(input logic wr, input logic [AW-1:0] addr, input logic [7:0] wd,
                             input logic [7:0] fill_base, input int ack_delay,
                             input bit toggle, input int abort_at);
        int cyc = 0;
        int nfill = 0;
        int nwb = 0;
        int ack_cyc = -1;
        bit wb_acked = 1'b0;
        bit aborted = 1'b0;
        bit prev_fill_req = 1'b0;
        bit prev_wb_req = 1'b0;
        o_rdata = 8'h00; o_fill_addr = '1; o_wb_addr = '1;
        o_ready_cyc = -1; o_comp_cyc = -1; o_fall_cyc = -1;
        o_req_cycles = 0; o_we_cycles = 0; o_fill_first = -1; o_wb_last = -1;
        o_ab_req = 1'b1; o_ab_ready = 1'b1;
        wb_q.delete();
        while (cyc < 400 && o_ready_cyc < 0) begin
            bus_sel = 1'b1; bus_write = wr; bus_addr = addr; bus_wdata = wd;
            line_ack = 1'b0; fill_valid = 1'b0; fill_data = 8'h00;
            wb_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (prev_fill_req && nfill < LB) begin
                if (abort_at >= 0 && nfill == abort_at) begin
                    aborted = 1'b1;
                end else begin
                    fill_valid = 1'b1;
                    fill_data  = fill_base + 8'(nfill);
                    if (nfill == 0) ack_cyc = cyc + LB - 1 + ack_delay;
                    nfill++;
                end
            end
            if (ack_cyc == cyc) line_ack = 1'b1;
            if (prev_wb_req && nwb == LB && !wb_acked) begin
                line_ack = 1'b1;
                wb_acked = 1'b1;
            end
            if (aborted) begin
                rst = 1'b1;
                step();
                rst = 1'b0; bus_sel = 1'b0; line_ack = 1'b0;
                #1;
                o_ab_req = line_req;
                o_ab_ready = bus_ready;
                step();
                break;
            end
            #1;
            if (line_req && line_we) begin
                o_wb_addr = line_addr; o_we_cycles++; o_wb_last = cyc;
            end
            if (line_req && !line_we) begin
                o_fill_addr = line_addr; o_req_cycles++;
                if (o_fill_first < 0) o_fill_first = cyc;
            end
            if (!line_req && prev_fill_req && o_fall_cyc < 0) o_fall_cyc = cyc;
            if (wb_valid && wb_ready) begin
                wb_q.push_back(wb_data);
                nwb++;
            end
            if (bus_ready) begin
                o_ready_cyc = cyc;
                o_rdata = bus_rdata;
            end
            prev_fill_req = line_req && !line_we;
            prev_wb_req = line_req && line_we;
            step();
            cyc++;
        end
        bus_sel = 1'b0; fill_valid = 1'b0; line_ack = 1'b0; wb_ready = 1'b0;
        if (nfill > 0) begin
            // Completion is the later of "count full" (cycle after last byte) and the ack pulse.
            if (ack_cyc > ack_cyc - ack_delay) o_comp_cyc = ack_cyc;
            else o_comp_cyc = ack_cyc - ack_delay + 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        #1;
        n_tests++;
        if (bus_ready !== 1'b0 || bus_rdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_bus: ready=%b rdata=%h required 0/00", bus_ready, bus_rdata);
        end
        n_tests++;
        if (line_req !== 1'b0 || line_we !== 1'b0 || line_addr !== '0) begin
            n_fail++; $display("FAIL reset_line: req=%b we=%b addr=%h required 0/0/0", line_req, line_we, line_addr);
        end
        n_tests++;
        if (wb_valid !== 1'b0 || wb_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_wb: valid=%b data=%h required 0/00", wb_valid, wb_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_clean_fill();
        do_access(1'b0, 23'h000010, 8'h00, 8'h00, 0, 1'b0, -1);
        n_tests++;
        if (o_fill_addr !== 18'h0) begin
            n_fail++; $display("FAIL fill_addr: got %h required 0", o_fill_addr);
        end
        n_tests++;
        if (o_rdata !== 8'h10) begin
            n_fail++; $display("FAIL fill_rdata: got %h required 10", o_rdata);
        end
        n_tests++;
        if (o_ready_cyc != o_comp_cyc + 2) begin
            n_fail++; $display("FAIL fill_ready_lat: got cycle %0d required %0d", o_ready_cyc, o_comp_cyc + 2);
        end
        n_tests++;
        if (o_we_cycles != 0) begin
            n_fail++; $display("FAIL fill_we: line_we high for %0d cycles required 0", o_we_cycles);
        end
        n_tests++;
        if (o_fall_cyc != o_comp_cyc + 1) begin
            n_fail++; $display("FAIL fill_req_fall: got cycle %0d required %0d", o_fall_cyc, o_comp_cyc + 1);
        end
    endtask

    task automatic test_write_hit();
        do_access(1'b1, 23'h000003, 8'hA5, 8'h00, 0, 1'b0, -1);
        n_tests++;
        if (o_ready_cyc != 2 || o_req_cycles != 0) begin
            n_fail++; $display("FAIL hit_write: ready cycle %0d req cycles %0d required 2/0", o_ready_cyc, o_req_cycles);
        end
        do_access(1'b0, 23'h000003, 8'h00, 8'h00, 0, 1'b0, -1);
        n_tests++;
        if (o_rdata !== 8'hA5 || o_ready_cyc != 2 || o_req_cycles != 0) begin
            n_fail++; $display("FAIL hit_read: rdata %h cycle %0d req %0d required A5/2/0", o_rdata, o_ready_cyc, o_req_cycles);
        end
    endtask

    task automatic test_dirty_miss();
        exp_q.delete();
        for (int i = 0; i < LB; i++) exp_q.push_back(8'(i));
        exp_q[3] = 8'hA5;
        do_access(1'b0, 23'h000040, 8'h00, 8'h40, 0, 1'b1, -1);
        n_tests++;
        if (o_wb_addr !== 18'h0) begin
            n_fail++; $display("FAIL wb_addr: got %h required 0", o_wb_addr);
        end
        n_tests++;
        if (wb_q.size() != LB) begin
            n_fail++; $display("FAIL wb_count: got %0d bytes required %0d", wb_q.size(), LB);
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [7:0] e;
            logic [7:0] g;
            e = exp_q.pop_front();
            g = (wb_q.size() > 0) ? wb_q.pop_front() : 8'hxx;
            n_tests++;
            if (g !== e) begin
                n_fail++; $display("FAIL wb_byte[%0d]: got %h required %h", i, g, e);
            end
        end
        n_tests++;
        if (o_fill_addr !== 18'h2 || o_fill_first - o_wb_last != 2) begin
            n_fail++; $display("FAIL wb_to_fill: fill addr %h gap %0d required 2/2", o_fill_addr, o_fill_first - o_wb_last);
        end
        n_tests++;
        if (o_rdata !== 8'h40 || o_ready_cyc != o_comp_cyc + 2) begin
            n_fail++; $display("FAIL dirty_miss_resp: rdata %h cycle %0d required 40/%0d", o_rdata, o_ready_cyc, o_comp_cyc + 2);
        end
    endtask

    task automatic test_ack_order();
        do_access(1'b0, 23'h000085, 8'h00, 8'h60, -10, 1'b0, -1);
        n_tests++;
        if (o_rdata !== 8'h65 || o_ready_cyc != o_comp_cyc + 2 || o_fall_cyc != o_comp_cyc + 1) begin
            n_fail++; $display("FAIL ack_early: rdata %h ready %0d fall %0d required 65/%0d/%0d",
                               o_rdata, o_ready_cyc, o_fall_cyc, o_comp_cyc + 2, o_comp_cyc + 1);
        end
        do_access(1'b0, 23'h0000A7, 8'h00, 8'h20, 5, 1'b0, -1);
        n_tests++;
        if (o_rdata !== 8'h27 || o_ready_cyc != o_comp_cyc + 2 || o_fall_cyc != o_comp_cyc + 1) begin
            n_fail++; $display("FAIL ack_late: rdata %h ready %0d fall %0d required 27/%0d/%0d",
                               o_rdata, o_ready_cyc, o_fall_cyc, o_comp_cyc + 2, o_comp_cyc + 1);
        end
        n_tests++;
        if (o_fill_addr !== 18'h5) begin
            n_fail++; $display("FAIL ack_late_addr: got %h required 5", o_fill_addr);
        end
    endtask

    task automatic test_reset_mid_fill();
        do_access(1'b0, 23'h000003, 8'h00, 8'h80, 0, 1'b0, 17);
        n_tests++;
        if (o_ready_cyc != -1 || o_ab_req !== 1'b0 || o_ab_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort: ready cycle %0d req %b ready %b required -1/0/0", o_ready_cyc, o_ab_req, o_ab_ready);
        end
        do_access(1'b0, 23'h000003, 8'h00, 8'hC0, 0, 1'b0, -1);
        n_tests++;
        if (o_rdata !== 8'hC3 || o_fill_addr !== 18'h0 || o_ready_cyc != o_comp_cyc + 2) begin
            n_fail++; $display("FAIL refill: rdata %h addr %h ready %0d required C3/0/%0d", o_rdata, o_fill_addr, o_ready_cyc, o_comp_cyc + 2);
        end
        do_access(1'b0, 23'h000014, 8'h00, 8'h00, 0, 1'b0, -1);
        n_tests++;
        if (o_rdata !== 8'hD4 || o_ready_cyc != 2) begin
            n_fail++; $display("FAIL refill_hit: rdata %h cycle %0d required D4/2", o_rdata, o_ready_cyc);
        end
    endtask

    task automatic test_write_allocate();
        do_access(1'b1, 23'h000123, 8'h5A, 8'h00, 0, 1'b0, -1);
        n_tests++;
        if (o_fill_addr !== 18'h9 || o_we_cycles != 0 || o_ready_cyc != o_comp_cyc + 2) begin
            n_fail++; $display("FAIL wr_alloc: addr %h we %0d ready %0d required 9/0/%0d", o_fill_addr, o_we_cycles, o_ready_cyc, o_comp_cyc + 2);
        end
        do_access(1'b0, 23'h000123, 8'h00, 8'h00, 0, 1'b0, -1);
        n_tests++;
        if (o_rdata !== 8'h5A || o_ready_cyc != 2) begin
            n_fail++; $display("FAIL wr_alloc_read: rdata %h cycle %0d required 5A/2", o_rdata, o_ready_cyc);
        end
        do_access(1'b0, 23'h000124, 8'h00, 8'h00, 0, 1'b0, -1);
        n_tests++;
        if (o_rdata !== 8'h04 || o_ready_cyc != 2) begin
            n_fail++; $display("FAIL wr_alloc_neighbour: rdata %h cycle %0d required 04/2", o_rdata, o_ready_cyc);
        end
    endtask

`ifdef SDRAM_FE_FLUSH_EN
    task automatic test_flush();
        int cyc = 0;
        int nwb = 0;
        bit acked = 1'b0;
        bit done_seen = 1'b0;
        bit prev_wb = 1'b0;
        logic [LW-1:0] addr_seen = '1;
        wb_q.delete();
        while (cyc < 200 && !done_seen) begin
            flush = 1'b1; wb_ready = 1'b1; line_ack = 1'b0;
            if (prev_wb && nwb == LB && !acked) begin
                line_ack = 1'b1;
                acked = 1'b1;
            end
            #1;
            if (line_req && line_we) addr_seen = line_addr;
            if (wb_valid && wb_ready) begin
                wb_q.push_back(wb_data);
                nwb++;
            end
            if (flush_done) done_seen = 1'b1;
            prev_wb = line_req && line_we;
            step();
            cyc++;
        end
        flush = 1'b0; line_ack = 1'b0; wb_ready = 1'b0;
        n_tests++;
        if (!done_seen || wb_q.size() != LB || addr_seen !== 18'h9) begin
            n_fail++; $display("FAIL flush_wb: done %b bytes %0d addr %h required 1/32/9", done_seen, wb_q.size(), addr_seen);
        end
        n_tests++;
        if (wb_q.size() < 4 || wb_q[3] !== 8'h5A) begin
            n_fail++; $display("FAIL flush_byte3: got %h required 5A", (wb_q.size() > 3) ? wb_q[3] : 8'hxx);
        end
        flush = 1'b1;
        #1;
        n_tests++;
        if (flush_done !== 1'b1 || line_req !== 1'b0) begin
            n_fail++; $display("FAIL flush_clean: done %b req %b required 1/0", flush_done, line_req);
        end
        step();
        flush = 1'b0;
        step();
        do_access(1'b0, 23'h000123, 8'h00, 8'h00, 0, 1'b0, -1);
        n_tests++;
        if (o_rdata !== 8'h5A || o_ready_cyc != 2 || o_req_cycles != 0) begin
            n_fail++; $display("FAIL flush_keeps_valid: rdata %h cycle %0d req %0d required 5A/2/0", o_rdata, o_ready_cyc, o_req_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_fill();
        test_write_hit();
        test_dirty_miss();
        test_ack_order();
        test_reset_mid_fill();
        test_write_allocate();
`ifdef SDRAM_FE_FLUSH_EN
        test_flush();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
